// File: rtl/x_mux_ddr_cfeb_tx.sv
// x_mux_ddr_cfeb_tx
// -----------------
// Transmit-side 2:1 multiplexer: turns 40 MHz paired data (1st-in-time,
// 2nd-in-time) into an 80 MHz DDR stream for the CFEB muonic link.
// Includes a programmable 0-15 bx launch delay, a half-cycle launch-phase
// select and an optional walking-ones pattern injector.
//
// Optional feature macro: CFEB_TX_PATTERN_EN
//   defined   : pattern FSM (IDLE/RUN/DONE), busy and done are live.
//   undefined : no FSM; inject_start/pat_len ignored; busy = done = 0.
//
// Ports
//   clock        in  1      40 MHz clock; falling edge used only by the DDR stage
//   clr          in  1      synchronous active-high clear (rising edge)
//   posneg       in  1      0: 1st on high half; 1: stream shifted half a cycle
//   delay_tx     in  4      launch delay in bx (0-15)
//   din1st       in  WIDTH  data sent 1st in time
//   din2nd       in  WIDTH  data sent 2nd in time
//   inject_start in  1      one-cycle request to start a pattern burst
//   pat_len      in  8      burst length minus 1, in bx
//   dout         out WIDTH  80 MHz DDR output
//   busy         out 1      pattern burst in progress
//   done         out 1      one-cycle pulse when a burst completes

module x_mux_ddr_cfeb_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             posneg,
  input  logic [3:0]       delay_tx,
  input  logic [WIDTH-1:0] din1st,
  input  logic [WIDTH-1:0] din2nd,
  input  logic             inject_start,
  input  logic [7:0]       pat_len,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  // ---------------------------------------------------------------------
  // Pattern source
  // ---------------------------------------------------------------------
  logic             use_pat;
  logic [WIDTH-1:0] pat1st;

`ifdef CFEB_TX_PATTERN_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  always_ff @(posedge clock) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Requests arriving in RUN or DONE are dropped, not queued.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (inject_start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == pat_len) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign use_pat = (state == RUN);
  // Walking one: bit (cnt mod WIDTH).
  assign pat1st  = {{(WIDTH-1){1'b0}}, 1'b1} << (32'(cnt) % WIDTH);
`else
  logic unused_pattern_inputs;
  assign unused_pattern_inputs = ^{inject_start, pat_len};
  assign busy    = 1'b0;
  assign done    = 1'b0;
  assign use_pat = 1'b0;
  assign pat1st  = '0;
`endif

  // ---------------------------------------------------------------------
  // Input stage and control buffering
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] s1st;
  logic [WIDTH-1:0] s2nd;
  logic             posneg_ff;
  logic [3:0]       dly;
  logic             dly_is_0;

  always_ff @(posedge clock) begin
    if (clr) begin
      s1st      <= '0;
      s2nd      <= '0;
      posneg_ff <= 1'b0;
      dly       <= '0;
      dly_is_0  <= 1'b0;
    end else begin
      s1st      <= use_pat ? pat1st  : din1st;
      s2nd      <= use_pat ? ~pat1st : din2nd;
      posneg_ff <= posneg;
      dly       <= delay_tx - 4'd1;
      dly_is_0  <= (delay_tx == 4'd0);
    end
  end

  // ---------------------------------------------------------------------
  // Delay stage: 16-deep shift buffers tapped at dly. Changing the tap does
  // not flush data already in flight. The buffers are cleared too, so a tap
  // read right after clr (control buffers at 0 select tap 0) returns 0.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sr1st [16];
  logic [WIDTH-1:0] sr2nd [16];
  logic [WIDTH-1:0] d1st;
  logic [WIDTH-1:0] d2nd;

  always_ff @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        sr1st[i] <= '0;
        sr2nd[i] <= '0;
      end
    end else begin
      sr1st[0] <= s1st;
      sr2nd[0] <= s2nd;
      for (int i = 1; i < 16; i++) begin
        sr1st[i] <= sr1st[i-1];
        sr2nd[i] <= sr2nd[i-1];
      end
    end
  end

  assign d1st = dly_is_0 ? s1st : sr1st[dly];
  assign d2nd = dly_is_0 ? s2nd : sr2nd[dly];

  // ---------------------------------------------------------------------
  // Output registers and DDR stage
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] hi_val;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] dout_rise;
  logic [WIDTH-1:0] dout_fall;

  // Value for the high half is what the rising edge is about to make
  // visible: the new q1 (posneg=0) or the new qp, i.e. the current q2
  // (posneg=1). The low half shows q2 (posneg=0) or q1 (posneg=1).
  assign hi_val = posneg_ff ? q2 : d1st;
  assign lo_val = posneg_ff ? q1 : q2;

  always_ff @(posedge clock) begin
    if (clr) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= d1st;
      q2 <= d2nd;
    end
  end

  // XOR-encoded DDR: each edge updates one register so that
  // dout_rise ^ dout_fall equals the wanted half-cycle value. Only one
  // register changes per edge, and clock never enters the data path.
  always_ff @(posedge clock) begin
    if (clr) dout_rise <= dout_fall;            // forces dout to 0
    else     dout_rise <= hi_val ^ dout_fall;
  end

  always_ff @(negedge clock) begin
    dout_fall <= lo_val ^ dout_rise;            // lo_val is 0 after clr
  end

  assign dout = dout_rise ^ dout_fall;

endmodule
